score_ram_responder: RTL and testbench
======================================

SCORE_RAM_RESPONDER -- requirements
Module: score_ram_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of 8-bit score entries.
REQ-002 SHALL have parameter WIDTH, default 8, score data width.
REQ-003 SHALL have parameter HI_ADDR, default 6, address of the high-score slot.
REQ-004 SHALL have parameter RSV_ADDR, default 7, reserved, write-protected address.
REQ-005 SHALL have port clk  input  1  clock; all logic is on the rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port we  input  1  write enable from the controller.
REQ-008 SHALL have port addr  input  3  entry address for both read and write.
REQ-009 SHALL have port wdata  input  WIDTH  write data.
REQ-010 SHALL have port rdata  output  WIDTH  registered read data, the controller's score_check.
REQ-011 SHALL have port rvalid  output  1  rdata holds a valid read result.
REQ-012 SHALL have port busy  output  1  initial clear sweep in progress.
REQ-013 SHALL have port wr_err  output  1  one-cycle pulse flagging a rejected write.
REQ-014 SHALL have port hi_score  output  WIDTH  registered copy of entry HI_ADDR.

Function
REQ-015 SHALL implement a two-state FSM: CLEAR and READY.
REQ-016 CLEAR SHALL write 0 to entry clr_idx each cycle, with clr_idx running 0..DEPTH-1; it SHALL go to READY on the cycle after clr_idx = DEPTH-1 (DEPTH cycles total).
REQ-017 busy SHALL be 1 in CLEAR and 0 in READY.
REQ-018 In READY, we=1 with addr != RSV_ADDR SHALL write mem[addr] <= wdata at that edge.
REQ-019 we=1 in CLEAR, or we=1 with addr = RSV_ADDR, SHALL leave memory unchanged and assert wr_err for exactly the following cycle.
REQ-020 Read latency SHALL be 2 edges. Edge N registers addr into addr_q. Edge N+1 loads rdata <= mem[addr_q]. rdata is stable from N+1 onward.
REQ-021 A write at edge N to the address sampled at edge N SHALL be visible in rdata loaded at edge N+1 (write-first).
REQ-022 A write at edge N+1 to addr_q SHALL NOT appear in rdata loaded at edge N+1; the old value is returned.
REQ-023 rvalid SHALL be 1 only when both pipeline stages captured their inputs in READY; rvalid SHALL be 0 throughout CLEAR and for 2 cycles after entering READY.
REQ-024 While busy=1, rdata SHALL be held at 0.
REQ-025 hi_score SHALL update one edge after any accepted write to HI_ADDR and SHALL otherwise hold its value.
REQ-026 Reads of RSV_ADDR SHALL return 0.
REQ-027 Addresses SHALL NOT wrap: addr >= DEPTH cannot occur at 3 bits with DEPTH = 8; for smaller DEPTH, out-of-range writes SHALL be treated as rejected (wr_err) and out-of-range reads SHALL return 0.

Reset
REQ-028 While rst=0 at an edge, the following SHALL hold: state=CLEAR, clr_idx=0, addr_q=0, rdata=0, rvalid=0, hi_score=0, wr_err=0, busy=1.
REQ-029 A reset asserted mid-sweep or mid-read SHALL abandon the operation; the full DEPTH-cycle sweep SHALL restart after rst returns to 1.
REQ-030 Memory contents SHALL be defined only by the clear sweep, not by reset itself.

Structure
REQ-031 A shared package SHALL hold the state encoding (CLEAR, READY), WIDTH, DEPTH, HI_ADDR and RSV_ADDR constants, shared with the RAM controller.
REQ-032 One sub-module, score_mem_array, SHALL contain the DEPTH x WIDTH register array, one write port and one combinational read port; the FSM, pipeline and error logic SHALL live in the top module.

Verification
REQ-033 Reset release: rst 0->1 -> busy=1 for 8 cycles then 0; rvalid rises 2 cycles later; reading every address 0..7 returns 0.
REQ-034 Write/read: in READY write addr=1, wdata=8 -> with addr=1 held, rdata=8 and rvalid=1 two edges later.
REQ-035 High score: write addr=6, wdata=0x2A -> hi_score=0x2A one edge later; write addr=3 -> hi_score unchanged.
REQ-036 Rejects: we=1 addr=7 wdata=0xFF -> wr_err pulses for 1 cycle and a read of address 7 returns 0; we=1 during CLEAR -> wr_err pulses and the entry stays 0 after the sweep.
REQ-037 Collision: address 2 holds 5, sample addr=2, then write addr=2 wdata=9 on the next edge -> rdata=5 is loaded, and a following read returns 9.
REQ-038 Mid-sweep reset: rst=0 at clr_idx=4 -> busy stays 1 and a fresh 8-cycle sweep runs after release.

Source files
------------

// File: rtl/score_ram_responder_pkg.sv
// Shared constants and state encoding for the score RAM responder and its controller.
package score_ram_responder_pkg;
    localparam int WIDTH    = 8;
    localparam int DEPTH    = 8;
    localparam int HI_ADDR  = 6;
    localparam int RSV_ADDR = 7;
    localparam int ADDR_W   = 3;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;
endpackage

// File: rtl/score_ram_responder_if.sv
// Controller <-> responder bus: write/read request and registered results.
interface score_ram_responder_if
    import score_ram_responder_pkg::*;
#(
    parameter int W = WIDTH
) ();
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [W-1:0]      wdata;
    logic [W-1:0]      rdata;
    logic              rvalid;
    logic              busy;
    logic              wr_err;
    logic [W-1:0]      hi_score;

    modport master (output we, addr, wdata,
                    input  rdata, rvalid, busy, wr_err, hi_score);
    modport slave  (input  we, addr, wdata,
                    output rdata, rvalid, busy, wr_err, hi_score);
endinterface

// File: rtl/score_mem_array.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational read port.
module score_mem_array #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Storage has no reset; contents come only from the clear sweep and writes.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/score_ram_responder.sv
// Score RAM responder: clear sweep after reset, protected writes, 2-edge read pipeline.
module score_ram_responder
    import score_ram_responder_pkg::*;
#(
    parameter int DEPTH    = score_ram_responder_pkg::DEPTH,
    parameter int WIDTH    = score_ram_responder_pkg::WIDTH,
    parameter int HI_ADDR  = score_ram_responder_pkg::HI_ADDR,
    parameter int RSV_ADDR = score_ram_responder_pkg::RSV_ADDR
) (
    input  logic                  clk,
    input  logic                  rst,
    score_ram_responder_if.slave  bus
);
    localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t            state, state_nx;
    logic [AW-1:0]     clr_idx;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        vld_pipe;
    logic [WIDTH-1:0]  rdata_q, hi_score_q, hi_data, mem_rdata, mem_wdata, rd_val;
    logic              wr_err_q, hi_pend;
    logic              busy, ready, wr_ok, wr_hit_hi, mem_we;
    logic [AW-1:0]     mem_waddr;

    // Accepted write: READY, in range, not the reserved slot.
    assign wr_ok     = ready && bus.we && (int'(bus.addr) < DEPTH)
                       && (bus.addr != ADDR_W'(RSV_ADDR));
    assign wr_hit_hi = wr_ok && (bus.addr == ADDR_W'(HI_ADDR));

    // Reserved and out-of-range reads return zero regardless of array contents.
    assign rd_val = ((int'(addr_q) < DEPTH) && (addr_q != ADDR_W'(RSV_ADDR)))
                    ? mem_rdata : '0;

    score_mem_array #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (addr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) state <= CLEAR;
        else      state <= state_nx;
    end

    // Next state: leave CLEAR once the last entry has been swept.
    always_comb begin
        state_nx = state;
        if (state == CLEAR && clr_idx == LAST) state_nx = READY;
    end

    // Outputs: sweep drives the array in CLEAR, the bus drives it in READY.
    always_comb begin
        busy      = (state == CLEAR);
        ready     = (state == READY);
        mem_we    = rst && wr_ok;
        mem_waddr = bus.addr[AW-1:0];
        mem_wdata = bus.wdata;
        if (state == CLEAR) begin
            mem_we    = rst;
            mem_waddr = clr_idx;
            mem_wdata = '0;
        end
    end

    // Sweep index; restarts from zero on every reset.
    always_ff @(posedge clk) begin
        if (!rst)                clr_idx <= '0;
        else if (state == CLEAR) clr_idx <= (clr_idx == LAST) ? '0 : clr_idx + 1'b1;
    end

    // Read pipeline, valid tracking and reject flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q   <= '0;
            rdata_q  <= '0;
            vld_pipe <= '0;
            wr_err_q <= 1'b0;
        end else begin
            addr_q   <= bus.addr;
            rdata_q  <= busy ? '0 : rd_val;
            vld_pipe <= {vld_pipe[0] & ready, ready};
            wr_err_q <= bus.we && !wr_ok;
        end
    end

    // High-score shadow: capture the write, publish it one edge later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_pend    <= 1'b0;
            hi_data    <= '0;
            hi_score_q <= '0;
        end else begin
            hi_pend <= wr_hit_hi;
            if (wr_hit_hi) hi_data    <= bus.wdata;
            if (hi_pend)   hi_score_q <= hi_data;
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.rvalid   = vld_pipe[1];
    assign bus.busy     = busy;
    assign bus.wr_err   = wr_err_q;
    assign bus.hi_score = hi_score_q;
endmodule

// File: tb/tb_score_ram_responder.sv
// Directed bench with a read scoreboard for score_ram_responder.
module tb_score_ram_responder;
    import score_ram_responder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    score_ram_responder_if bus ();

    score_ram_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q [$];
    logic [7:0] model [8];
    int         n;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'd1);
            chk(tag, 32'(bus.rdata), 32'(e));
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus.we    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        step();
        bus.we = 1'b0;
        if (a != 3'(RSV_ADDR)) model[a] = d;
    endtask

    task automatic rd(input logic [2:0] a, input string tag);
        bus.addr = a;
        exp_q.push_back(model[a]);
        step();
        step();
        pop_chk(tag);
    endtask

    // Count cycles until busy falls, bounded.
    task automatic sweep_len(output int cnt);
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 20) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        foreach (model[i]) model[i] = 8'h00;

        // Reset state
        rst = 1'b0;
        step();
        step();
        chk("rst_busy",   32'(bus.busy),     32'd1);
        chk("rst_rvalid", 32'(bus.rvalid),   32'd0);
        chk("rst_rdata",  32'(bus.rdata),    32'd0);
        chk("rst_hi",     32'(bus.hi_score), 32'd0);
        chk("rst_wr_err", 32'(bus.wr_err),   32'd0);

        // Release: sweep with a rejected write injected mid-sweep
        rst = 1'b1;
        n = 0;
        while (bus.busy === 1'b1 && n < 20) begin
            if (n == 2) begin
                bus.we = 1'b1; bus.addr = 3'd3; bus.wdata = 8'hAA;
            end
            step();
            n++;
            if (n == 3) begin
                chk("clear_wr_err", 32'(bus.wr_err), 32'd1);
                bus.we = 1'b0; bus.addr = 3'd0;
            end
            if (n == 4) chk("clear_wr_err_off", 32'(bus.wr_err), 32'd0);
        end
        chk("sweep_len", 32'(n), 32'd8);
        chk("rvalid_ready0", 32'(bus.rvalid), 32'd0);
        step();
        chk("rvalid_ready1", 32'(bus.rvalid), 32'd0);
        step();
        chk("rvalid_ready2", 32'(bus.rvalid), 32'd1);

        // Every entry reads zero after the sweep
        for (int a = 0; a < 8; a++) rd(3'(a), $sformatf("clr_rd%0d", a));

        // Write-first read-back
        wr(3'd1, 8'd8);
        step();
        chk("wf_rdata",  32'(bus.rdata),  32'd8);
        chk("wf_rvalid", 32'(bus.rvalid), 32'd1);
        rd(3'd1, "rd1");

        // High-score shadow
        wr(3'd6, 8'h2A);
        step();
        chk("hi_set", 32'(bus.hi_score), 32'h2A);
        wr(3'd3, 8'h33);
        chk("acc_wr_err", 32'(bus.wr_err), 32'd0);
        step();
        chk("hi_hold", 32'(bus.hi_score), 32'h2A);
        rd(3'd3, "rd3");
        rd(3'd6, "rd6");

        // Reserved slot rejects writes and reads zero
        wr(3'd7, 8'hFF);
        chk("rsv_wr_err", 32'(bus.wr_err), 32'd1);
        step();
        chk("rsv_wr_err_off", 32'(bus.wr_err), 32'd0);
        rd(3'd7, "rd7");

        // Read/write collision returns the old value
        wr(3'd2, 8'd5);
        bus.addr = 3'd2;
        exp_q.push_back(8'd5);
        step();
        bus.we = 1'b1;
        bus.wdata = 8'd9;
        step();
        bus.we = 1'b0;
        model[2] = 8'd9;
        pop_chk("coll_old");
        exp_q.push_back(8'd9);
        step();
        pop_chk("coll_new");

        // Reset in the middle of a sweep restarts it
        rst = 1'b0;
        step();
        rst = 1'b1;
        repeat (4) step();
        chk("mid_busy_pre", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        step();
        chk("mid_busy",   32'(bus.busy),     32'd1);
        chk("mid_rvalid", 32'(bus.rvalid),   32'd0);
        chk("mid_hi",     32'(bus.hi_score), 32'd0);
        rst = 1'b1;
        sweep_len(n);
        chk("sweep_len2", 32'(n), 32'd8);
        foreach (model[i]) model[i] = 8'h00;
        rd(3'd2, "post_rd2");
        rd(3'd6, "post_rd6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
